// File: rtl/debug_panel.sv
// Paged 7-segment debug display with a built-in page button debouncer.
// Optional build macro DEBUG_PANEL_LZB_EN enables per-channel leading-zero blanking.
module debug_panel #(
  parameter  int CHANNELS        = 5,
  parameter  int CH_PER_PAGE     = 2,
  parameter  int DEBOUNCE_CYCLES = 50000,
  parameter  int SCAN_DIVIDE     = 1000,
  localparam int DIGITS          = 4 * CH_PER_PAGE,
  localparam int PAGES           = (CHANNELS + CH_PER_PAGE - 1) / CH_PER_PAGE,
  localparam int PAGE_W          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [16*CHANNELS-1:0] ch_data,
  input  logic                   page_btn,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      dig_en,
  output logic [PAGE_W-1:0]      page,
  output logic                   page_step
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PSC_W = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef logic [15:0] word_t;

  // Channel words regrouped by page; slots past the last channel read as zero.
  word_t page_words [PAGES][CH_PER_PAGE];

  for (genvar p = 0; p < PAGES; p++) begin : g_page
    for (genvar c = 0; c < CH_PER_PAGE; c++) begin : g_slot
      localparam int K = p * CH_PER_PAGE + c;
      if (K < CHANNELS) begin : g_present
        assign page_words[p][c] = ch_data[16*K +: 16];
      end else begin : g_absent
        assign page_words[p][c] = '0;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [PSC_W-1:0]       psc_q, psc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   start_q, start_d;
  logic [PAGE_W-1:0]      pend_q, pend_d, page_q, page_d;
  word_t                  snap_q [CH_PER_PAGE];
  word_t                  snap_d [CH_PER_PAGE];
  logic [CH_PER_PAGE-1:0] snap_ok_q, snap_ok_d;
  logic                   btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d, arm_cnt_q, arm_cnt_d;
  logic                   db_q, db_d, armed_q, armed_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      dig_en_q, dig_en_d;
  logic                   step_q, step_d;

  logic                   scan_tc, frame_load, cur_ok, blank;
  word_t                  cur_word;
  logic [3:0]             nib;

  // NOTE: every next-state value gets a default first so no path leaves a latch behind.
  always_comb begin
    psc_d      = psc_q + PSC_W'(1);
    idx_d      = idx_q;
    start_d    = 1'b0;
    pend_d     = pend_q;
    page_d     = page_q;
    snap_d     = snap_q;
    snap_ok_d  = snap_ok_q;
    btn_meta_d = page_btn;
    btn_sync_d = btn_meta_q;
    db_d       = db_q;
    db_cnt_d   = '0;
    armed_d    = armed_q;
    arm_cnt_d  = '0;
    cur_word   = '0;
    cur_ok     = 1'b0;
    nib        = '0;

    scan_tc = (psc_q == PSC_W'(SCAN_DIVIDE - 1));
    if (scan_tc) begin
      psc_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    frame_load = start_q | (scan_tc & (idx_q == IDX_W'(DIGITS - 1)));

    if (btn_sync_q != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) db_d = btn_sync_q;
      else                                         db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // Arming needs a full debounce window of a genuinely released button, so a
    // press held through reset can never look like a fresh rising edge.
    if (!armed_q && !btn_sync_q && !db_q) begin
      if (arm_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) armed_d = 1'b1;
      else                                          arm_cnt_d = arm_cnt_q + DB_W'(1);
    end

    step_d = armed_q & db_d & ~db_q;
    if (step_d) pend_d = (pend_q == PAGE_W'(PAGES - 1)) ? '0 : pend_q + PAGE_W'(1);

    if (frame_load) begin
      page_d = pend_q;
      for (int c = 0; c < CH_PER_PAGE; c++) begin
        snap_d[c]    = page_words[pend_q][c];
        snap_ok_d[c] = (int'(pend_q) * CH_PER_PAGE + c) < CHANNELS;
      end
    end

    for (int c = 0; c < CH_PER_PAGE; c++) begin
      if (int'(idx_q) / 4 == c) begin
        cur_word = snap_q[c];
        cur_ok   = snap_ok_q[c];
      end
    end
    case (idx_q[1:0])
      2'd0:    nib = cur_word[3:0];
      2'd1:    nib = cur_word[7:4];
      2'd2:    nib = cur_word[11:8];
      default: nib = cur_word[15:12];
    endcase

    blank = ~cur_ok;
`ifdef DEBUG_PANEL_LZB_EN
    case (idx_q[1:0])
      2'd1:    blank = blank | (cur_word[15:4] == '0);
      2'd2:    blank = blank | (cur_word[15:8] == '0);
      2'd3:    blank = blank | (cur_word[15:12] == '0);
      default: blank = blank;
    endcase
`endif

    seg_d    = blank ? 7'h7F : hex7(nib);
    dig_en_d = ~(DIGITS'(1) << idx_q);
  end

  // NOTE: state is updated only here, with non-blocking assignments, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_q      <= '0;
      idx_q      <= '0;
      start_q    <= 1'b1;
      pend_q     <= '0;
      page_q     <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset to
      // keep the first displayed frame deterministic.
      for (int c = 0; c < CH_PER_PAGE; c++) snap_q[c] <= '0;
      snap_ok_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_cnt_q   <= '0;
      db_q       <= 1'b0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      seg_q      <= 7'h7F;
      dig_en_q   <= '1;
      step_q     <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      pend_q     <= pend_d;
      page_q     <= page_d;
      snap_q     <= snap_d;
      snap_ok_q  <= snap_ok_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      db_cnt_q   <= db_cnt_d;
      db_q       <= db_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
      step_q     <= step_d;
    end
  end

  assign seg       = seg_q;
  assign dig_en    = dig_en_q;
  assign page      = page_q;
  assign page_step = step_q;

endmodule
